// File: rtl/dm_pkg.sv
// Shared constants for the matrix-multiplication processor data memory.
package dm_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned ADDR_WIDTH = 8;
   localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
   localparam int unsigned NUM_PORTS  = 5;

   // Port indices; a lower index wins a same-address write collision.
   localparam int unsigned PORT_FILE = 0;
   localparam int unsigned PORT_C0   = 1;
   localparam int unsigned PORT_C1   = 2;
   localparam int unsigned PORT_C2   = 3;
   localparam int unsigned PORT_C3   = 4;

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/dm_write_arbiter.sv
// Combinational write arbiter: resolves same-address write collisions by
// fixed priority (lowest port index wins) and emits a per-port commit mask.
module dm_write_arbiter
   import dm_pkg::*;
(
   input  logic [NUM_PORTS-1:0]                 en,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr,
   output logic [NUM_PORTS-1:0]                 commit
);

   logic [NUM_PORTS-1:0] en_ok;
   logic                 won;

   // Only a definite 1 counts as a write request; X or Z falls to no-write.
   always_comb begin
      en_ok = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (en[p]) en_ok[p] = 1'b1;
      end
   end

   // A port commits unless a higher-priority enabled port targets the same word.
   always_comb begin
      commit = '0;
      won    = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         won = en_ok[p];
         for (int q = 0; q < p; q++) begin
            if (en_ok[q] && (addr[q] == addr[p])) won = 1'b0;
         end
         commit[p] = won;
      end
   end

endmodule

// File: rtl/data_memory_4port.sv
// Shared 256 x 16 data memory with one host port and four core ports.
// Every port reads synchronously (read-first) and may write; colliding
// writes are resolved by dm_write_arbiter.
module data_memory_4port
   import dm_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_en_file,
   input  logic [ADDR_WIDTH-1:0] addr_file,
   input  logic [DATA_WIDTH-1:0] data_file,
   output logic [DATA_WIDTH-1:0] dataout_file,
   input  logic                  write_en0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] datain0,
   output logic [DATA_WIDTH-1:0] dataout0,
   input  logic                  write_en1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] datain1,
   output logic [DATA_WIDTH-1:0] dataout1,
   input  logic                  write_en2,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] datain2,
   output logic [DATA_WIDTH-1:0] dataout2,
   input  logic                  write_en3,
   input  logic [ADDR_WIDTH-1:0] addr3,
   input  logic [DATA_WIDTH-1:0] datain3,
   output logic [DATA_WIDTH-1:0] dataout3
);

   logic [NUM_PORTS-1:0]                 en_vec;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_vec;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_vec;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_q;
   logic [NUM_PORTS-1:0]                 commit;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign en_vec   = {write_en3, write_en2, write_en1, write_en0, write_en_file};
   assign addr_vec = {addr3, addr2, addr1, addr0, addr_file};
   assign data_vec = {datain3, datain2, datain1, datain0, data_file};

   dm_write_arbiter u_arbiter (
      .en     (en_vec),
      .addr   (addr_vec),
      .commit (commit)
   );

   // Storage update: reset blocks writes but never clears the array.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (commit[p]) mem[addr_vec[p]] <= data_vec[p];
         end
      end
   end

   // Read registers: old word is returned when a same-edge write hits the address.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            rd_q[p] <= mem[addr_vec[p]];
         end
      end
   end

   assign dataout_file = rd_q[PORT_FILE];
   assign dataout0     = rd_q[PORT_C0];
   assign dataout1     = rd_q[PORT_C1];
   assign dataout2     = rd_q[PORT_C2];
   assign dataout3     = rd_q[PORT_C3];

endmodule

// File: tb/tb_data_memory_4port.sv
// Directed self-checking bench for data_memory_4port.
module tb_data_memory_4port;

   logic        clock = 1'b0;
   logic        reset;
   logic        write_en_file, write_en0, write_en1, write_en2, write_en3;
   logic [7:0]  addr_file, addr0, addr1, addr2, addr3;
   logic [15:0] data_file, datain0, datain1, datain2, datain3;
   logic [15:0] dataout_file, dataout0, dataout1, dataout2, dataout3;

   int errors = 0;
   int checks = 0;

   logic [15:0] pre_vals [6] = '{16'd2, 16'd2, 16'd2, 16'd1, 16'd2, 16'd3};
   logic [15:0] par_vals [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

   always #5 clock = ~clock;

   data_memory_4port dut (
      .clock         (clock),
      .reset         (reset),
      .write_en_file (write_en_file),
      .addr_file     (addr_file),
      .data_file     (data_file),
      .dataout_file  (dataout_file),
      .write_en0     (write_en0),
      .addr0         (addr0),
      .datain0       (datain0),
      .dataout0      (dataout0),
      .write_en1     (write_en1),
      .addr1         (addr1),
      .datain1       (datain1),
      .dataout1      (dataout1),
      .write_en2     (write_en2),
      .addr2         (addr2),
      .datain2       (datain2),
      .dataout2      (dataout2),
      .write_en3     (write_en3),
      .addr3         (addr3),
      .datain3       (datain3),
      .dataout3      (dataout3)
   );

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] exp);
      check({tag, "/file"}, dataout_file, exp);
      check({tag, "/c0"}, dataout0, exp);
      check({tag, "/c1"}, dataout1, exp);
      check({tag, "/c2"}, dataout2, exp);
      check({tag, "/c3"}, dataout3, exp);
   endtask

   task automatic all_addr(input logic [7:0] a);
      addr_file = a; addr0 = a; addr1 = a; addr2 = a; addr3 = a;
   endtask

   task automatic no_writes();
      write_en_file = 1'b0; write_en0 = 1'b0; write_en1 = 1'b0;
      write_en2 = 1'b0; write_en3 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      no_writes();
      all_addr(8'd0);
      data_file = '0; datain0 = '0; datain1 = '0; datain2 = '0; datain3 = '0;

      // Reset clears every read register.
      tick();
      check_all("reset", 16'h0000);
      reset = 1'b0;

      // Preload dims and a few words through the host port, then dump them.
      for (int i = 0; i < 6; i++) begin
         write_en_file = 1'b1;
         addr_file     = 8'(i);
         data_file     = pre_vals[i];
         tick();
      end
      write_en_file = 1'b0;
      for (int i = 0; i < 6; i++) begin
         addr_file = 8'(i);
         tick();
         check($sformatf("dump%0d", i), dataout_file, pre_vals[i]);
      end

      // Four cores write distinct addresses in one cycle.
      write_en0 = 1'b1; addr0 = 8'd10; datain0 = 16'h0011;
      write_en1 = 1'b1; addr1 = 8'd11; datain1 = 16'h0022;
      write_en2 = 1'b1; addr2 = 8'd12; datain2 = 16'h0033;
      write_en3 = 1'b1; addr3 = 8'd13; datain3 = 16'h0044;
      tick();
      no_writes();
      for (int k = 0; k < 4; k++) begin
         all_addr(8'(10 + k));
         tick();
         check_all($sformatf("par%0d", k), par_vals[k]);
      end

      // Host beats core0 on a same-address collision.
      write_en_file = 1'b1; addr_file = 8'd20; data_file = 16'hAAAA;
      write_en0     = 1'b1; addr0     = 8'd20; datain0   = 16'hBBBB;
      addr1 = 8'd0; addr2 = 8'd0; addr3 = 8'd0;
      tick();
      no_writes();
      all_addr(8'd20);
      tick();
      check("coll_file_c0", dataout_file, 16'hAAAA);

      // Core1 beats core3.
      write_en1 = 1'b1; datain1 = 16'h0001;
      write_en3 = 1'b1; datain3 = 16'h0003;
      tick();
      no_writes();
      tick();
      check("coll_c1_c3", dataout0, 16'h0001);

      // Read-first on a same-edge write.
      write_en_file = 1'b1; addr_file = 8'd30; data_file = 16'h0005;
      tick();
      write_en_file = 1'b0;
      write_en2 = 1'b1; addr2 = 8'd30; datain2 = 16'h0009;
      tick();
      check("rfw_old", dataout2, 16'h0005);
      write_en2 = 1'b0;
      tick();
      check("rfw_new", dataout2, 16'h0009);

      // Reset suppresses a pending write and leaves the array intact.
      write_en_file = 1'b1; addr_file = 8'd40; data_file = 16'h0001;
      tick();
      write_en_file = 1'b0;
      all_addr(8'd40);
      tick();
      check("pre_rst", dataout_file, 16'h0001);
      reset = 1'b1;
      write_en1 = 1'b1; datain1 = 16'h7777;
      tick();
      check_all("rst_mid", 16'h0000);
      reset = 1'b0;
      write_en1 = 1'b0;
      tick();
      check_all("post_rst", 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
